// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t   : receiver FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS    : data bits per 8N1 frame
//   STOP_BITS    : stop bits per 8N1 frame
//   clks_per_bit : system clocks per bit time (integer division)
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   // Result must be at least 4 so the half-bit start check has room.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, start/data/stop FSM and bit timing.
// Ports:
//   clk_in, rst_in  : clock, async active-high reset
//   uart_rxd        : raw serial line (idles high)
//   rx_byte         : last accepted byte (registered)
//   rx_valid        : one-cycle pulse when rx_byte updates
//   rx_frame_err    : one-cycle pulse after a bad stop bit
//   rx_data         : shift register contents (complete byte while in STOP)
//   rx_accept       : combinational, good stop bit sampled this cycle
//   rx_reject       : combinational, bad stop bit sampled this cycle
//   rx_start        : combinational, start edge seen while idle
//   rx_idle         : FSM is idle
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       uart_rxd,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic [7:0] rx_data,
   output logic       rx_accept,
   output logic       rx_reject,
   output logic       rx_start,
   output logic       rx_idle
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_START = START;
   localparam logic [1:0] ST_DATA  = DATA;
   localparam logic [1:0] ST_STOP  = STOP;

   logic             sync_1, sync_2, rxd_d;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] bit_idx;
   logic [7:0]       shreg;
   logic             expire, fall;

   // Counter is loaded with a full (or half) bit time and the sample is
   // taken on the cycle it reaches 1, i.e. exactly that many cycles later.
   assign expire    = (cnt <= CNT_W'(1));
   assign fall      = rxd_d & ~sync_2;
   assign rx_start  = (state == ST_IDLE) && fall;
   assign rx_accept = (state == ST_STOP) && expire && sync_2;
   assign rx_reject = (state == ST_STOP) && expire && !sync_2;
   assign rx_idle   = (state == ST_IDLE);
   assign rx_data   = shreg;

   // Line idles high, so the synchronizer resets to 1 to avoid a false start.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         rxd_d  <= 1'b1;
      end else begin
         sync_1 <= uart_rxd;
         sync_2 <= sync_1;
         rxd_d  <= sync_2;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fall) begin
                  state <= ST_START;
                  cnt   <= CNT_W'(CLKS_PER_BIT / 2);
               end
            end
            ST_START: begin
               if (expire) begin
                  // Line back high at mid start bit: treat as a glitch.
                  if (!sync_2) begin
                     state   <= ST_DATA;
                     bit_idx <= '0;
                     cnt     <= CNT_W'(CLKS_PER_BIT);
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (expire) begin
                  shreg <= {sync_2, shreg[7:1]};
                  cnt   <= CNT_W'(CLKS_PER_BIT);
                  if (bit_idx == IDX_W'(DATA_BITS - 1)) state <= ST_STOP;
                  else bit_idx <= bit_idx + IDX_W'(1);
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               // Leave at mid stop bit so a back-to-back start edge is seen.
               if (expire) state <= ST_IDLE;
               else cnt <= cnt - CNT_W'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rx_byte      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_valid     <= rx_accept;
         rx_frame_err <= rx_reject;
         if (rx_accept) rx_byte <= shreg;
      end
   end

endmodule

// File: rtl/uart_word_rx.sv
// UART receiver that packs little-endian byte groups into words.
// Ports:
//   clk_in, rst_in  : clock, async active-high reset
//   uart_rxd        : serial line from the host (idles high)
//   byte_out        : last received byte
//   byte_valid_out  : one-cycle pulse when byte_out updates
//   word_out        : assembled word, first byte in [7:0]
//   word_valid_out  : word available, held until accepted
//   word_ready_in   : consumer accepts on valid && ready
//   frame_err_out   : one-cycle pulse on a bad stop bit
//   overrun_out     : one-cycle pulse when a completed word is dropped
module uart_word_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BAUD         = 115_200,
   parameter int WORD_BYTES   = 4,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    uart_rxd,
   output logic [7:0]              byte_out,
   output logic                    byte_valid_out,
   output logic [8*WORD_BYTES-1:0] word_out,
   output logic                    word_valid_out,
   input  logic                    word_ready_in,
   output logic                    frame_err_out,
   output logic                    overrun_out
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
   localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W         = $clog2(TO_CYCLES + 1);
   localparam int IDX_W        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

   logic [7:0] rx_data;
   logic       rx_accept, rx_reject, rx_start, rx_idle;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .uart_rxd     (uart_rxd),
      .rx_byte      (byte_out),
      .rx_valid     (byte_valid_out),
      .rx_frame_err (frame_err_out),
      .rx_data      (rx_data),
      .rx_accept    (rx_accept),
      .rx_reject    (rx_reject),
      .rx_start     (rx_start),
      .rx_idle      (rx_idle)
   );

   logic [WORD_BYTES-1:0][7:0] part, word_full;
   logic [IDX_W-1:0]           idx;
   logic [TO_W-1:0]            idle_cnt;
   logic                       last_byte, hold_free, load, timeout_hit;

   assign last_byte   = (idx == IDX_W'(WORD_BYTES - 1));
   assign hold_free   = !word_valid_out || word_ready_in;
   // Word commits on the stop-sample edge, so it appears together with
   // the byte_valid_out pulse of its last byte.
   assign load        = rx_accept && last_byte && hold_free;
   assign timeout_hit = (idle_cnt == TO_W'(TO_CYCLES - 1));

   // The last lane is taken straight from the shift register.
   always_comb begin
      word_full                 = part;
      word_full[WORD_BYTES-1]   = rx_data;
   end

   // Idle counter only runs while a partial word is waiting in IDLE.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         idle_cnt <= '0;
      end else if (!rx_idle || rx_start || idx == '0 || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + TO_W'(1);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         part <= '0;
         idx  <= '0;
      end else if (rx_reject || timeout_hit) begin
         part <= '0;
         idx  <= '0;
      end else if (rx_accept) begin
         if (last_byte) begin
            part <= '0;
            idx  <= '0;
         end else begin
            part[idx] <= rx_data;
            idx       <= idx + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         word_out       <= '0;
         word_valid_out <= 1'b0;
         overrun_out    <= 1'b0;
      end else begin
         overrun_out <= rx_accept && last_byte && !hold_free;
         if (load) begin
            word_out       <= word_full;
            word_valid_out <= 1'b1;
         end else if (word_valid_out && word_ready_in) begin
            word_valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_word_rx.sv
module tb_uart_word_rx;

   localparam int CLK_HZ = 100_000_000;
   localparam int BAUD   = 12_500_000;
   localparam int WB     = 4;
   localparam int TOB    = 32;
   localparam int CPB    = 8;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        uart_rxd = 1'b1;
   logic        word_ready_in = 1'b1;
   logic [7:0]  byte_out;
   logic        byte_valid_out;
   logic [31:0] word_out;
   logic        word_valid_out;
   logic        frame_err_out;
   logic        overrun_out;

   always #5 clk_in = ~clk_in;

   uart_word_rx #(
      .CLK_HZ       (CLK_HZ),
      .BAUD         (BAUD),
      .WORD_BYTES   (WB),
      .TIMEOUT_BITS (TOB)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .uart_rxd       (uart_rxd),
      .byte_out       (byte_out),
      .byte_valid_out (byte_valid_out),
      .word_out       (word_out),
      .word_valid_out (word_valid_out),
      .word_ready_in  (word_ready_in),
      .frame_err_out  (frame_err_out),
      .overrun_out    (overrun_out)
   );

   int checks = 0;
   int errors = 0;

   // Observed events, sampled on the falling edge.
   logic [7:0]  got_bytes[$];
   logic [31:0] got_words[$];
   int          got_ferr = 0, got_ovr = 0, wv_bad = 0;
   logic        prev_wv = 1'b0, prev_acc = 1'b0;

   always @(negedge clk_in) begin
      if (byte_valid_out) got_bytes.push_back(byte_out);
      if (frame_err_out) got_ferr++;
      if (overrun_out) got_ovr++;
      // A word may only appear together with the byte pulse that completes it,
      // and must drop the cycle after acceptance unless a new one loads.
      if (word_valid_out && !prev_wv && !byte_valid_out) wv_bad++;
      if (prev_acc && word_valid_out && !byte_valid_out) wv_bad++;
      if (word_valid_out && word_ready_in) got_words.push_back(word_out);
      prev_wv  = word_valid_out;
      prev_acc = word_valid_out && word_ready_in;
   end

   // Reference model: bytes/words expected from the frames sent.
   logic [7:0]  exp_bytes[$];
   logic [31:0] exp_words[$];
   logic [7:0]  mpart[$];
   int          exp_ferr = 0, exp_ovr = 0;
   bit          hold_v = 1'b0;
   logic [31:0] hold_w = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit ok);
      logic [31:0] w;
      if (!ok) begin
         exp_ferr++;
         mpart.delete();
         return;
      end
      exp_bytes.push_back(b);
      mpart.push_back(b);
      if (mpart.size() == WB) begin
         w = '0;
         for (int i = 0; i < WB; i++) w = w | (32'(mpart[i]) << (8 * i));
         mpart.delete();
         if (word_ready_in) exp_words.push_back(w);
         else if (!hold_v) begin hold_v = 1'b1; hold_w = w; end
         else exp_ovr++;
      end
   endtask

   task automatic set_ready(input logic v);
      word_ready_in = v;
      if (v && hold_v) begin
         exp_words.push_back(hold_w);
         hold_v = 1'b0;
      end
   endtask

   task automatic drive_bit(input logic v);
      uart_rxd = v;
      tick(CPB);
   endtask

   task automatic send(input logic [7:0] b, input bit ok);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(ok);
      if (!ok) drive_bit(1'b1);
      model_frame(b, ok);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < WB; i++) send(w[8*i +: 8], 1'b1);
   endtask

   task automatic verify(input string tag);
      tick(2 * CPB);
      check({tag, " byte count"}, got_bytes.size(), exp_bytes.size());
      for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
         check({tag, " byte"}, got_bytes[i], exp_bytes[i]);
      check({tag, " word count"}, got_words.size(), exp_words.size());
      for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
         check({tag, " word"}, got_words[i], exp_words[i]);
      check({tag, " frame_err pulses"}, got_ferr, exp_ferr);
      check({tag, " overrun pulses"}, got_ovr, exp_ovr);
      check({tag, " valid timing"}, wv_bad, 0);
      check({tag, " word_valid"}, word_valid_out, hold_v);
      got_bytes.delete(); exp_bytes.delete();
      got_words.delete(); exp_words.delete();
      got_ferr = 0; exp_ferr = 0; got_ovr = 0; exp_ovr = 0; wv_bad = 0;
   endtask

   initial begin
      // Reset state
      tick(3);
      check("reset byte_out", byte_out, 0);
      check("reset byte_valid", byte_valid_out, 0);
      check("reset word_out", word_out, 0);
      check("reset word_valid", word_valid_out, 0);
      check("reset frame_err", frame_err_out, 0);
      check("reset overrun", overrun_out, 0);
      rst_in = 1'b0;
      tick(4);

      // 1: word assembly
      send_word(32'h1234_5678);
      verify("assembly");

      // 2: glitch then a good frame
      uart_rxd = 1'b0;
      tick(3);
      uart_rxd = 1'b1;
      tick(2 * CPB);
      check("glitch no byte", got_bytes.size(), 0);
      check("glitch no frame_err", got_ferr, 0);
      send(8'h5A, 1'b1);
      verify("glitch");

      // 3: framing error clears the partial word
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      send(8'hA5, 1'b0);
      send_word(32'h0403_0201);
      verify("frame error");

      // 4: backpressure and overrun
      set_ready(1'b0);
      send_word(32'hDEAD_BEEF);
      send_word(32'h0102_0304);
      tick(2);
      check("bp word_out held", word_out, hold_w);
      check("bp valid held", word_valid_out, hold_v);
      check("bp overrun", got_ovr, exp_ovr);
      set_ready(1'b1);
      tick(1);
      check("bp valid drops", word_valid_out, hold_v);
      verify("backpressure");

      // 5: timeout discards a partial word
      send(8'hAA, 1'b1);
      send(8'hBB, 1'b1);
      tick(300);
      mpart.delete();
      send_word(32'h0403_0201);
      verify("timeout");

      // 6: reset mid-byte with a held word outstanding
      set_ready(1'b0);
      send_word($urandom);
      verify("pre-reset");
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1);
      uart_rxd = 1'b0;
      tick(3);
      #2 rst_in = 1'b1;
      #1;
      check("mid reset word_out", word_out, 0);
      check("mid reset word_valid", word_valid_out, 0);
      check("mid reset byte_out", byte_out, 0);
      check("mid reset byte_valid", byte_valid_out, 0);
      mpart.delete();
      hold_v = 1'b0;
      uart_rxd = 1'b1;
      tick(2);
      rst_in = 1'b0;
      set_ready(1'b1);
      tick(2);
      send_word(32'h1234_5678);
      verify("after reset");

      // Random frames with occasional bad stop bits and back-to-back starts
      for (int k = 0; k < 16; k++) begin
         logic [7:0] b;
         b = 8'($urandom);
         send(b, $urandom_range(0, 5) != 0);
         tick($urandom_range(0, 2) * CPB);
      end
      verify("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "bench time limit reached");
   end

endmodule
